// File: rtl/wb_daq_pkg.sv
// Shared definitions for the DAQ playback disaggregator: FSM encodings,
// legal sample widths, lane-count helper and underrun counter width.
package wb_daq_pkg;

    localparam int UNDERRUN_W = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SERVE = 2'd3;

    localparam int ADC_DW_8  = 8;
    localparam int ADC_DW_16 = 16;
    localparam int ADC_DW_32 = 32;

    function automatic bit is_legal_adc_dw(input int w);
        return (w == ADC_DW_8) || (w == ADC_DW_16) || (w == ADC_DW_32);
    endfunction

    function automatic int lanes_of(input int word_w, input int sample_w);
        return word_w / sample_w;
    endfunction

endpackage

// File: rtl/wb_daq_word_buffer.sv
// dw-bit word holding register with load, clear and a valid flag.
// Clear wins over load so a flush can never be overridden by a capture.
module wb_daq_word_buffer #(
    parameter int dw = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          load,
    input  logic          clear,
    input  logic [dw-1:0] data_in,
    output logic [dw-1:0] data_out,
    output logic          valid
);

    // Hold the word and its valid flag until cleared or reloaded.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (clear) begin
            valid    <= 1'b0;
        end else if (load) begin
            data_out <= data_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_daq_data_disaggregation.sv
// Playback disaggregator: pops dw-bit words from the playback FIFO and
// hands them to the DAC one adc_dw-bit lane per sample_req, lane 0 first.
// Optional build macro WB_DAQ_DISAGG_PREFETCH_EN adds a next-word buffer
// so the FIFO is read ahead and back-to-back requests never starve.
//
// state | meaning
// IDLE  | disabled / flushed, waiting for enable
// FETCH | no word held, pop FIFO when it is non-empty
// WAIT  | pop outstanding, capture FIFO read data this cycle
// SERVE | current word valid, one lane per request
module wb_daq_data_disaggregation
    import wb_daq_pkg::*;
#(
    parameter int dw     = 32,
    parameter int adc_dw = 8
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [dw-1:0]         fifo_data_in,
    output logic                  fifo_pop,
    input  logic                  sample_req,
    output logic [adc_dw-1:0]     dac_data_out,
    output logic                  dac_data_valid,
    output logic                  underrun,
    output logic [UNDERRUN_W-1:0] underrun_count
);

    localparam int LANES = lanes_of(dw, adc_dw);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic              cur_load, cur_clear, cur_valid;
    logic [dw-1:0]     cur_din, cur_data;
    logic [adc_dw-1:0] lane_sel;
    logic              req_ok, consume, last;

    assign req_ok  = enable && sample_req;
    assign consume = req_ok && cur_valid;
    assign last    = consume && (idx == LAST_IDX);

    wb_daq_word_buffer #(.dw(dw)) u_cur_buf (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .load     (cur_load),
        .clear    (cur_clear),
        .data_in  (cur_din),
        .data_out (cur_data),
        .valid    (cur_valid)
    );

`ifdef WB_DAQ_DISAGG_PREFETCH_EN
    logic          nxt_load, nxt_clear, nxt_valid;
    logic [dw-1:0] nxt_data;
    logic          pop_q;

    wb_daq_word_buffer #(.dw(dw)) u_nxt_buf (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .load     (nxt_load),
        .clear    (nxt_clear),
        .data_in  (fifo_data_in),
        .data_out (nxt_data),
        .valid    (nxt_valid)
    );

    // Read ahead while serving; pop_q blocks a second pop while one is returning.
    assign fifo_pop = enable && !fifo_empty &&
                      ((state == ST_FETCH) ||
                       ((state == ST_SERVE) && cur_valid && !nxt_valid && !pop_q));

    // Remember that FIFO read data arrives this cycle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)
            pop_q <= 1'b0;
        else
            pop_q <= fifo_pop;
    end
`else
    assign fifo_pop = enable && !fifo_empty && (state == ST_FETCH);
`endif

    // Buffer load/clear steering: flush, first capture, end-of-word refill.
    always_comb begin
        cur_load  = 1'b0;
        cur_clear = 1'b0;
        cur_din   = fifo_data_in;
`ifdef WB_DAQ_DISAGG_PREFETCH_EN
        nxt_load  = 1'b0;
        nxt_clear = 1'b0;
        if (!enable) begin
            cur_clear = 1'b1;
            nxt_clear = 1'b1;
        end else if (state == ST_WAIT) begin
            cur_load = 1'b1;
        end else if (last) begin
            // Promote the next word (or the word arriving now) without a gap.
            if (nxt_valid) begin
                cur_din   = nxt_data;
                cur_load  = 1'b1;
                nxt_clear = 1'b1;
            end else if (pop_q) begin
                cur_load = 1'b1;
            end else begin
                cur_clear = 1'b1;
            end
        end else if ((state == ST_SERVE) && pop_q) begin
            nxt_load = 1'b1;
        end
`else
        if (!enable)
            cur_clear = 1'b1;
        else if (state == ST_WAIT)
            cur_load = 1'b1;
        else if (last)
            cur_clear = 1'b1;
`endif
    end

    // Select the lane addressed by idx from the current word.
    always_comb begin
        lane_sel = cur_data[adc_dw-1:0];
        for (int l = 0; l < LANES; l++) begin
            if (idx == IDX_W'(l))
                lane_sel = cur_data[l*adc_dw +: adc_dw];
        end
    end

    // Sequencing FSM and lane index; enable low flushes to IDLE.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else if (!enable) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE:  state <= ST_FETCH;
                ST_FETCH: if (fifo_pop) state <= ST_WAIT;
                ST_WAIT: begin
                    state <= ST_SERVE;
                    idx   <= '0;
                end
                ST_SERVE: begin
                    if (last) begin
                        idx <= '0;
`ifdef WB_DAQ_DISAGG_PREFETCH_EN
                        if (!nxt_valid && !pop_q)
                            state <= fifo_pop ? ST_WAIT : ST_FETCH;
`else
                        state <= ST_FETCH;
`endif
                    end else if (consume) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sample output, valid/underrun pulses and saturating underrun counter.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            dac_data_out   <= '0;
            dac_data_valid <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            dac_data_valid <= 1'b0;
            underrun       <= 1'b0;
            if (consume) begin
                dac_data_out   <= lane_sel;
                dac_data_valid <= 1'b1;
            end else if (req_ok) begin
                underrun <= 1'b1;
                if (underrun_count != '1)
                    underrun_count <= underrun_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_daq_data_disaggregation.sv
// Bench for wb_daq_data_disaggregation: directed plan cases plus a random
// run scored against a lane-stream model built from the words popped.
module tb_wb_daq_data_disaggregation;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;

    logic        en_a, req_a, empty_a, pop_a, dv_a, ur_a;
    logic [31:0] din_a = '0;
    logic [7:0]  dout_a;
    logic [15:0] urc_a;

    logic        en_b, req_b, empty_b, pop_b, dv_b, ur_b;
    logic [31:0] din_b = '0;
    logic [15:0] dout_b;
    logic [15:0] urc_b;

    always #5 wb_clk = ~wb_clk;

    wb_daq_data_disaggregation #(.dw(32), .adc_dw(8)) u_dut_a (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .enable         (en_a),
        .fifo_empty     (empty_a),
        .fifo_data_in   (din_a),
        .fifo_pop       (pop_a),
        .sample_req     (req_a),
        .dac_data_out   (dout_a),
        .dac_data_valid (dv_a),
        .underrun       (ur_a),
        .underrun_count (urc_a)
    );

    wb_daq_data_disaggregation #(.dw(32), .adc_dw(16)) u_dut_b (
        .wb_clk         (wb_clk),
        .wb_rst         (wb_rst),
        .enable         (en_b),
        .fifo_empty     (empty_b),
        .fifo_data_in   (din_b),
        .fifo_pop       (pop_b),
        .sample_req     (req_b),
        .dac_data_out   (dout_b),
        .dac_data_valid (dv_b),
        .underrun       (ur_b),
        .underrun_count (urc_b)
    );

    // Behavioural FIFOs: initial block owns write pointers, always owns reads.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [7:0]  wp_a, wp_b;
    logic [7:0]  rp_a = '0;
    logic [7:0]  rp_b = '0;
    int          bad_pop_a = 0;
    int          bad_pop_b = 0;
    int          pops_b = 0;

    assign empty_a = (wp_a == rp_a);
    assign empty_b = (wp_b == rp_b);

    always @(posedge wb_clk) begin
        if (pop_a) begin
            if (empty_a) bad_pop_a <= bad_pop_a + 1;
            din_a <= mem_a[rp_a];
            rp_a  <= rp_a + 8'd1;
        end
        if (pop_b) begin
            if (empty_b) bad_pop_b <= bad_pop_b + 1;
            din_b  <= mem_b[rp_b];
            rp_b   <= rp_b + 8'd1;
            pops_b <= pops_b + 1;
        end
    end

    int          checks, errors;
    logic [7:0]  sq[$];
    logic [15:0] exp_urc;
    logic [7:0]  last_out;
    int          pop_cnt, smp_cnt, ur_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_a(input logic [31:0] w);
        mem_a[wp_a] = w;
        wp_a = wp_a + 8'd1;
    endtask

    // One clock of DUT A with scoreboarding of the response to this request.
    task automatic cyc_a(input logic req);
        logic [7:0] e;
        req_a = req;
        @(negedge wb_clk);
        if (pop_a) begin
            pop_cnt++;
            for (int l = 0; l < 4; l++) sq.push_back(mem_a[rp_a][8*l +: 8]);
        end
        if (!en_a) sq.delete();
        @(posedge wb_clk);
        #1;
        req_a = 1'b0;
        if (req && en_a) check("resp_one", {31'b0, dv_a ^ ur_a}, 32'd1);
        else             check("no_resp", {30'b0, dv_a, ur_a}, 32'd0);
        if (dv_a) begin
            smp_cnt++;
            if (sq.size() == 0) begin
                check("sample_avail", 32'd0, 32'd1);
            end else begin
                e = sq.pop_front();
                check("sample", dout_a, e);
            end
            last_out = dout_a;
        end else begin
            check("dout_hold", dout_a, last_out);
        end
        if (ur_a) begin
            ur_cnt++;
            if (exp_urc != 16'hFFFF) exp_urc = exp_urc + 16'd1;
        end
        check("urc", urc_a, exp_urc);
    endtask

    task automatic flush_a();
        en_a = 1'b0;
        cyc_a(1'b0);
        cyc_a(1'b0);
        wp_a = rp_a;
    endtask

    task automatic do_reset();
        wb_rst = 1'b1;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
        sq.delete();
        exp_urc  = '0;
        last_out = '0;
    endtask

    logic [15:0] exp16 [4];
    int p0, s0, u0;
    logic rq;

    initial begin
        checks = 0; errors = 0;
        en_a = 0; req_a = 0; en_b = 0; req_b = 0;
        wp_a = '0; wp_b = '0;
        exp_urc = '0; last_out = '0;
        pop_cnt = 0; smp_cnt = 0; ur_cnt = 0;
        exp16[0] = 16'hAAAA; exp16[1] = 16'hBBBB;
        exp16[2] = 16'hCCCC; exp16[3] = 16'hDDDD;

        repeat (2) @(posedge wb_clk);
        #1;
        check("rst_dout", dout_a, 0);
        check("rst_valid", dv_a, 0);
        check("rst_ur", ur_a, 0);
        check("rst_urc", urc_a, 0);
        check("rst_pop", pop_a, 0);
        check("rst_dout_b", dout_b, 0);
        wb_rst = 1'b0;

        // Empty FIFO: every request underruns, nothing popped.
        en_a = 1'b1;
        p0 = pop_cnt; u0 = ur_cnt;
        repeat (4) cyc_a(1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc_a(1'b1);
            cyc_a(1'b0);
        end
        check("empty_ur", ur_cnt - u0, 3);
        check("empty_urc", urc_a, 16'd3);
        check("empty_pop", pop_cnt - p0, 0);
        check("empty_dout", dout_a, 0);

        // Single word, requests 4 cycles apart, lane 0 first.
        flush_a();
        push_a(32'h44332211);
        p0 = pop_cnt; s0 = smp_cnt; u0 = ur_cnt;
        en_a = 1'b1;
        repeat (4) cyc_a(1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1);
            repeat (3) cyc_a(1'b0);
        end
        check("w1_pops", pop_cnt - p0, 1);
        check("w1_samples", smp_cnt - s0, 4);
        check("w1_ur", ur_cnt - u0, 0);
        check("w1_last", dout_a, 8'h44);

        // 16-bit instance: two words, requests every 8 cycles.
        flush_a();
        mem_b[wp_b] = 32'hBBBBAAAA; wp_b = wp_b + 8'd1;
        mem_b[wp_b] = 32'hDDDDCCCC; wp_b = wp_b + 8'd1;
        en_b = 1'b1;
        repeat (4) begin @(posedge wb_clk); #1; end
        for (int i = 0; i < 4; i++) begin
            req_b = 1'b1;
            @(posedge wb_clk);
            #1;
            req_b = 1'b0;
            check("b_valid", dv_b, 1);
            check("b_sample", dout_b, exp16[i]);
            check("b_ur", ur_b, 0);
            repeat (7) begin @(posedge wb_clk); #1; end
        end
        check("b_pops", pops_b, 2);
        check("b_urc", urc_b, 0);
        en_b = 1'b0;

        // Flush after two lanes; remaining lanes must never appear.
        flush_a();
        push_a(32'h44332211);
        en_a = 1'b1;
        repeat (4) cyc_a(1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc_a(1'b1);
            repeat (3) cyc_a(1'b0);
        end
        check("fl_pre", dout_a, 8'h22);
        en_a = 1'b0;
        cyc_a(1'b1);
        cyc_a(1'b0);
        push_a(32'h88776655);
        p0 = pop_cnt;
        en_a = 1'b1;
        repeat (4) cyc_a(1'b0);
        check("fl_repop", pop_cnt - p0, 1);
        cyc_a(1'b1);
        check("fl_lane0", dout_a, 8'h55);

        // Back-to-back requests with a well-stocked FIFO.
        flush_a();
        for (int i = 0; i < 10; i++) push_a(32'h03020100);
        en_a = 1'b1;
        repeat (4) cyc_a(1'b0);
        s0 = smp_cnt; u0 = ur_cnt;
        repeat (24) cyc_a(1'b1);
`ifdef WB_DAQ_DISAGG_PREFETCH_EN
        check("b2b_samples", smp_cnt - s0, 24);
        check("b2b_ur", ur_cnt - u0, 0);
`else
        check("b2b_samples", smp_cnt - s0, 16);
        check("b2b_ur", ur_cnt - u0, 8);
`endif

        // Random traffic with occasional enable drops.
        flush_a();
        s0 = smp_cnt;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) push_a($urandom);
            en_a = ($urandom_range(0, 39) != 0);
            rq   = ($urandom_range(0, 2) == 0);
            cyc_a(rq);
        end
        check("rand_progress", {31'b0, (smp_cnt - s0) > 20}, 32'd1);

        // Saturation of the underrun counter.
        flush_a();
        do_reset();
        en_a  = 1'b1;
        req_a = 1'b1;
        repeat (65535) @(posedge wb_clk);
        #1;
        req_a = 1'b0;
        check("sat_reach", urc_a, 16'hFFFF);
        exp_urc = 16'd65535;
        cyc_a(1'b1);
        check("sat_pulse", ur_a, 1);
        check("sat_hold", urc_a, 16'hFFFF);

        // Asynchronous reset in the middle of SERVE.
        push_a(32'h44332211);
        repeat (4) cyc_a(1'b0);
        cyc_a(1'b1);
        check("ar_pre", dout_a, 8'h11);
        #2;
        wb_rst = 1'b1;
        #1;
        check("ar_dout", dout_a, 0);
        check("ar_valid", dv_a, 0);
        check("ar_ur", ur_a, 0);
        check("ar_urc", urc_a, 0);
        check("ar_pop", pop_a, 0);
        en_a = 1'b0;
        @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;

        check("bad_pop_a", bad_pop_a, 0);
        check("bad_pop_b", bad_pop_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
